// File: rtl/var_std_if.sv
// var_std_if: mean/E[x^2] input slots and result channel of the variance/std stage
interface var_std_if;
    logic [15:0] mean_in;
    logic        mean_valid;
    logic        mean_ready;
    logic [31:0] ex2_in;
    logic        ex2_valid;
    logic        ex2_ready;
    logic [31:0] var_out;
    logic [15:0] std_out;
    logic        clamp_out;
    logic        out_valid;
    logic        out_ready;
    modport master (
        output mean_in, mean_valid, ex2_in, ex2_valid, out_ready,
        input  mean_ready, ex2_ready, var_out, std_out, clamp_out, out_valid
    );
    modport slave (
        input  mean_in, mean_valid, ex2_in, ex2_valid, out_ready,
        output mean_ready, ex2_ready, var_out, std_out, clamp_out, out_valid
    );
endinterface

// File: rtl/var_std_module.sv
// var_std_module: joins row mean and E[x^2], emits var = E[x^2] - mean^2 + EPS
// and std = floor(sqrt(var)) from a 16-step restoring square root
module var_std_module #(
    parameter logic [31:0] EPS = 32'h0000_0000
) (
    input logic clk,
    input logic rst_n,
    var_std_if.slave bus
);
    typedef enum logic [2:0] {COLLECT, SQ, SUB, ROOT, DONE} state_t;
    state_t state, state_nx;
    logic [15:0] mean_q, root, std_q;
    logic [31:0] ex2_q, sq, var_q, rad, var_o, var_sat;
    logic [19:0] rem, rem_sh, trial, rem_nx;
    logic [4:0] cnt;
    logic mean_held, ex2_held, clamp_q, clamp_o, out_valid;
    logic mean_acc, ex2_acc, ge;
    logic signed [31:0] m32;
    logic [32:0] diff, sum;
    always_comb begin
        bus.mean_ready = rst_n && state == COLLECT && !mean_held;
        bus.ex2_ready = rst_n && state == COLLECT && !ex2_held;
        mean_acc = bus.mean_valid && bus.mean_ready;
        ex2_acc = bus.ex2_valid && bus.ex2_ready;
        m32 = {{16{mean_q[15]}}, mean_q};
        diff = {1'b0, ex2_q} - {1'b0, sq};
        sum = {1'b0, diff[32] ? 32'h0 : diff[31:0]} + {1'b0, EPS};
        var_sat = sum[32] ? 32'hFFFF_FFFF : sum[31:0];
        // remainder stays below 2^18, so the top bits of the shift drop safely
        rem_sh = 20'({rem, rad[31:30]});
        trial = {2'b00, root, 2'b01};
        ge = rem_sh >= trial;
        rem_nx = ge ? rem_sh - trial : rem_sh;
    end
    always_comb begin
        state_nx = state;
        case (state)
            COLLECT: state_nx = ((mean_held || mean_acc) && (ex2_held || ex2_acc)) ? SQ : COLLECT;
            SQ:      state_nx = SUB;
            SUB:     state_nx = ROOT;
            ROOT:    state_nx = cnt == 5'd15 ? DONE : ROOT;
            DONE:    state_nx = bus.out_ready ? COLLECT : DONE;
            default: state_nx = COLLECT;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) state <= COLLECT;
        else state <= state_nx;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mean_q <= '0;
            ex2_q <= '0;
            mean_held <= 1'b0;
            ex2_held <= 1'b0;
            sq <= '0;
            var_q <= '0;
            rad <= '0;
            rem <= '0;
            root <= '0;
            cnt <= '0;
            clamp_q <= 1'b0;
            var_o <= '0;
            std_q <= '0;
            clamp_o <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (mean_acc) begin
                        mean_q <= bus.mean_in;
                        mean_held <= 1'b1;
                    end
                    if (ex2_acc) begin
                        ex2_q <= bus.ex2_in;
                        ex2_held <= 1'b1;
                    end
                end
                SQ: sq <= m32 * m32;
                SUB: begin
                    var_q <= var_sat;
                    rad <= var_sat;
                    clamp_q <= diff[32];
                    rem <= '0;
                    root <= '0;
                    cnt <= '0;
                end
                ROOT: begin
                    rem <= rem_nx;
                    root <= {root[14:0], ge};
                    rad <= {rad[29:0], 2'b00};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        var_o <= var_q;
                        std_q <= {root[14:0], ge};
                        clamp_o <= clamp_q;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        mean_held <= 1'b0;
                        ex2_held <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
    assign bus.var_out = var_o;
    assign bus.std_out = std_q;
    assign bus.clamp_out = clamp_o;
    assign bus.out_valid = out_valid;
endmodule

// File: tb/tb_var_std_module.sv
// tb_var_std_module: directed vectors for var_std_module (EPS = 0 and EPS = 1 instances)
module tb_var_std_module;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    var_std_if b();
    var_std_if b1();
    var_std_module dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));
    var_std_module #(.EPS(32'h0000_0001)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    int checks = 0;
    int errors = 0;
    int lat;
    logic seen;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic send_pair(input logic [15:0] m, input logic [31:0] e);
        b.mean_in = m;
        b.ex2_in = e;
        b.mean_valid = 1'b1;
        b.ex2_valid = 1'b1;
        step();
        b.mean_valid = 1'b0;
        b.ex2_valid = 1'b0;
    endtask
    task automatic wait_out(output int n);
        n = 0;
        while (!b.out_valid && n < 60) begin
            step();
            n++;
        end
    endtask
    task automatic take;
        b.out_ready = 1'b1;
        step();
        b.out_ready = 1'b0;
    endtask
    task automatic row(input string tag, input logic [15:0] m, input logic [31:0] e,
                       input logic [31:0] v, input logic [15:0] s, input logic c);
        int n;
        send_pair(m, e);
        wait_out(n);
        check({tag, "_lat"}, n, 18);
        check({tag, "_var"}, b.var_out, v);
        check({tag, "_std"}, b.std_out, s);
        check({tag, "_clamp"}, b.clamp_out, c);
        take();
        check({tag, "_vld_clr"}, b.out_valid, 0);
        check({tag, "_rdy"}, {b.mean_ready, b.ex2_ready}, 2'b11);
    endtask
    initial begin
        b.mean_in = '0; b.mean_valid = 1'b0; b.ex2_in = '0; b.ex2_valid = 1'b0; b.out_ready = 1'b0;
        b1.mean_in = '0; b1.mean_valid = 1'b0; b1.ex2_in = '0; b1.ex2_valid = 1'b0; b1.out_ready = 1'b0;
        repeat (3) step();
        check("rst_vld", b.out_valid, 0);
        check("rst_var", b.var_out, 0);
        check("rst_std", b.std_out, 0);
        check("rst_clamp", b.clamp_out, 0);
        check("rst_rdy_low", {b.mean_ready, b.ex2_ready}, 2'b00);
        rst_n = 1'b1;
        #1;
        check("rst_rdy_high", {b.mean_ready, b.ex2_ready}, 2'b11);
        row("basic", 16'h0100, 32'h0004_0000, 32'h0003_0000, 16'h01BB, 1'b0);
        row("clamp_pos", 16'h0200, 32'h0001_0000, 32'h0, 16'h0, 1'b1);
        row("clamp_neg", 16'hFE00, 32'h0001_0000, 32'h0, 16'h0, 1'b1);
        row("square", 16'h0000, 32'h0009_0000, 32'h0009_0000, 16'h0300, 1'b0);
        row("max_eps0", 16'h0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 1'b0);
        // saturation on the EPS = 1 instance
        b1.mean_in = 16'h0000;
        b1.ex2_in = 32'hFFFF_FFFF;
        b1.mean_valid = 1'b1;
        b1.ex2_valid = 1'b1;
        step();
        b1.mean_valid = 1'b0;
        b1.ex2_valid = 1'b0;
        lat = 0;
        while (!b1.out_valid && lat < 60) begin
            step();
            lat++;
        end
        check("sat_lat", lat, 18);
        check("sat_var", b1.var_out, 32'hFFFF_FFFF);
        check("sat_std", b1.std_out, 16'hFFFF);
        check("sat_clamp", b1.clamp_out, 0);
        b1.out_ready = 1'b1;
        step();
        b1.out_ready = 1'b0;
        check("sat_vld_clr", b1.out_valid, 0);
        // ex2 first, mean five cycles later
        b.ex2_in = 32'h0009_0000;
        b.ex2_valid = 1'b1;
        step();
        b.ex2_valid = 1'b0;
        check("join_ex2_rdy", b.ex2_ready, 0);
        check("join_mean_rdy", b.mean_ready, 1);
        repeat (4) step();
        check("join_mean_rdy_late", b.mean_ready, 1);
        check("join_ex2_rdy_late", b.ex2_ready, 0);
        check("join_no_out", b.out_valid, 0);
        b.mean_in = 16'h0000;
        b.mean_valid = 1'b1;
        step();
        b.mean_valid = 1'b0;
        wait_out(lat);
        check("join_lat", lat, 18);
        check("join_std", b.std_out, 16'h0300);
        take();
        // same-cycle pair while a further ex2 waits
        send_pair(16'h0100, 32'h0004_0000);
        b.ex2_in = 32'h1234_5678;
        b.ex2_valid = 1'b1;
        wait_out(lat);
        check("same_lat", lat, 18);
        check("same_var", b.var_out, 32'h0003_0000);
        check("same_std", b.std_out, 16'h01BB);
        check("hold_ex2_rdy", b.ex2_ready, 0);
        take();
        check("hold_rdy_after", {b.mean_ready, b.ex2_ready}, 2'b11);
        step();
        b.ex2_valid = 1'b0;
        check("hold_ex2_taken", b.ex2_ready, 0);
        b.mean_in = 16'h0000;
        b.mean_valid = 1'b1;
        step();
        b.mean_valid = 1'b0;
        wait_out(lat);
        check("hold_lat", lat, 18);
        check("hold_var", b.var_out, 32'h1234_5678);
        check("hold_std", b.std_out, 16'h4444);
        take();
        // output backpressure
        send_pair(16'h0200, 32'h0005_0000);
        wait_out(lat);
        check("bp_lat", lat, 18);
        for (int i = 0; i < 7; i++) begin
            step();
            check("bp_vld", b.out_valid, 1);
            check("bp_var", b.var_out, 32'h0001_0000);
            check("bp_std", b.std_out, 16'h0100);
            check("bp_rdy", {b.mean_ready, b.ex2_ready}, 2'b00);
        end
        take();
        check("bp_vld_clr", b.out_valid, 0);
        check("bp_rdy_after", {b.mean_ready, b.ex2_ready}, 2'b11);
        // reset in the middle of the root iterations
        send_pair(16'h0100, 32'h0004_0000);
        repeat (9) step();
        rst_n = 1'b0;
        step();
        check("mrst_vld", b.out_valid, 0);
        check("mrst_var", b.var_out, 0);
        check("mrst_std", b.std_out, 0);
        check("mrst_clamp", b.clamp_out, 0);
        check("mrst_rdy", {b.mean_ready, b.ex2_ready}, 2'b00);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            step();
            if (b.out_valid) seen = 1'b1;
        end
        check("mrst_no_emit", seen, 0);
        row("post_rst", 16'h0000, 32'h0009_0000, 32'h0009_0000, 16'h0300, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
